// File: rtl/ex_div_unit_pkg.sv
// Shared definitions for the EX-stage divider: default widths, RV32M divide
// op encodings and the FSM state type.
package ex_div_unit_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = 6;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } div_state_e;

endpackage

// File: rtl/ex_div_unit_div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and shifts the resulting quotient bit in at the LSB.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   i_remainder,
    input  logic [DATA_W-1:0] i_quotient,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W:0]   o_remainder,
    output logic [DATA_W-1:0] o_quotient
);

    logic [DATA_W+1:0] w_diff;
    logic              w_fits;

    // The extra top bit of the difference acts as the borrow/sign flag.
    assign w_diff = {i_remainder, i_quotient[DATA_W-1]} - {2'b00, i_divisor};
    assign w_fits = ~w_diff[DATA_W+1];

    assign o_remainder = w_fits ? w_diff[DATA_W:0]
                                : {i_remainder[DATA_W-1:0], i_quotient[DATA_W-1]};
    assign o_quotient  = {i_quotient[DATA_W-2:0], w_fits};

endmodule

// File: rtl/ex_div_unit.sv
// Iterative radix-2 divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Requests a pipeline stall while busy and holds its result under EX stalls.
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic [DATA_W-1:0] result_o,
    output logic              ready_o,
    output logic              stallreq_o
);

    div_state_e r_state;
    div_state_e w_nextState;

    logic [DATA_W:0]   r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_div;
    logic [DATA_W-1:0] r_result;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_isRem;
    logic              r_negQ;
    logic              r_negR;

    logic              w_signed;
    logic              w_isRem;
    logic              w_negA;
    logic              w_negB;
    logic [DATA_W-1:0] w_absA;
    logic [DATA_W-1:0] w_absB;
    logic              w_divZero;
    logic              w_overflow;
    logic              w_special;
    logic [DATA_W-1:0] w_specialResult;
    logic [DATA_W:0]   w_stepRem;
    logic [DATA_W-1:0] w_stepQuo;
    logic [DATA_W-1:0] w_remLow;
    logic [DATA_W-1:0] w_fixedResult;
    logic              w_lastStep;

    assign w_signed   = (op_i == OP_DIV) || (op_i == OP_REM);
    assign w_isRem    = (op_i == OP_REM) || (op_i == OP_REMU);
    assign w_negA     = w_signed & dividend_i[DATA_W-1];
    assign w_negB     = w_signed & divisor_i[DATA_W-1];
    assign w_absA     = w_negA ? -dividend_i : dividend_i;
    assign w_absB     = w_negB ? -divisor_i : divisor_i;
    assign w_divZero  = (divisor_i == '0);
    assign w_overflow = w_signed && (dividend_i == {1'b1, {(DATA_W-1){1'b0}}}) && (&divisor_i);
    assign w_special  = w_divZero | w_overflow;

    // Divide-by-zero and INT_MIN/-1 bypass the iteration entirely.
    always_comb begin
        w_specialResult = '0;
        if (w_divZero) begin
            w_specialResult = w_isRem ? dividend_i : '1;
        end else if (w_overflow) begin
            w_specialResult = w_isRem ? '0 : dividend_i;
        end
    end

    div_step #(
        .DATA_W(DATA_W)
    ) u_step (
        .i_remainder(r_rem),
        .i_quotient (r_quo),
        .i_divisor  (r_div),
        .o_remainder(w_stepRem),
        .o_quotient (w_stepQuo)
    );

    assign w_remLow      = w_stepRem[DATA_W-1:0];
    assign w_lastStep    = (r_cnt == CNT_W'(DATA_W - 1));
    assign w_fixedResult = r_isRem ? (r_negR ? -w_remLow : w_remLow)
                                   : (r_negQ ? -w_stepQuo : w_stepQuo);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Flush wins over everything; start dropping mid-calculation also aborts.
    always_comb begin
        w_nextState = r_state;
        ready_o     = 1'b0;
        result_o    = '0;
        if (r_state == ST_DONE) begin
            ready_o  = 1'b1;
            result_o = r_result;
        end
        if (flush_i) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        w_nextState = w_special ? ST_DONE : ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (!start_i) begin
                        w_nextState = ST_IDLE;
                    end else if (w_lastStep) begin
                        w_nextState = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!stall_i) begin
                        w_nextState = ST_IDLE;
                    end
                end
                default: w_nextState = ST_IDLE;
            endcase
        end
    end

    assign stallreq_o = start_i & ~ready_o & ~flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_isRem  <= 1'b0;
            r_negQ   <= 1'b0;
            r_negR   <= 1'b0;
        end else if (!flush_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_isRem <= w_isRem;
                        r_negQ  <= w_negA ^ w_negB;
                        r_negR  <= w_negA;
                        r_cnt   <= '0;
                        if (w_special) begin
                            r_result <= w_specialResult;
                        end else begin
                            r_rem <= '0;
                            r_quo <= w_absA;
                            r_div <= w_absB;
                        end
                    end
                end
                ST_CALC: begin
                    if (start_i) begin
                        r_rem <= w_stepRem;
                        r_quo <= w_stepQuo;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_lastStep) begin
                            r_result <= w_fixedResult;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed self-checking bench for ex_div_unit: latency, signed/unsigned
// results, special cases, flush, EX stall hold and asynchronous reset.
module tb_ex_div_unit;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        flush_i;
    logic        stall_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int errors = 0;
    int checks = 0;

    logic readyBad;

    ex_div_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .op_i      (op_i),
        .dividend_i(dividend_i),
        .divisor_i (divisor_i),
        .flush_i   (flush_i),
        .stall_i   (stall_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic start, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic flush, input logic stall);
        start_i    = start;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        flush_i    = flush;
        stall_i    = stall;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Starts a divide in the current (IDLE) cycle, waits for ready, optionally
    // holds DONE under stall_i, then lets the pipeline advance.
    task automatic runDivide(input string tag, input logic [1:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] expResult, input int expLat,
                             input int holdCycles);
        int   cyc;
        logic stallBad;
        logic holdBad;
        cyc      = 0;
        stallBad = 1'b0;
        holdBad  = 1'b0;
        applyStimulus(1'b1, op, a, b, 1'b0, 1'b0);
        #1;
        checkOutput({tag, " stallreq c0"}, {31'b0, stallreq_o}, 32'd1);
        while (!ready_o && cyc < 80) begin
            tick();
            cyc++;
            if (!ready_o && !stallreq_o) stallBad = 1'b1;
        end
        checkOutput({tag, " latency"}, 32'(cyc), 32'(expLat));
        checkOutput({tag, " result"}, result_o, expResult);
        checkOutput({tag, " stallreq busy"}, {31'b0, stallBad}, 32'd0);
        checkOutput({tag, " stallreq done"}, {31'b0, stallreq_o}, 32'd0);
        for (int k = 0; k < holdCycles; k++) begin
            stall_i = 1'b1;
            tick();
            if (!ready_o || result_o !== expResult || stallreq_o) holdBad = 1'b1;
        end
        stall_i = 1'b0;
        if (holdCycles > 0) checkOutput({tag, " hold"}, {31'b0, holdBad}, 32'd0);
        tick();
        start_i = 1'b0;
        #1;
        checkOutput({tag, " ready drop"}, {31'b0, ready_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, DIVU, 32'd0, 32'd0, 1'b0, 1'b0);
        #12;
        checkOutput("reset result", result_o, 32'd0);
        checkOutput("reset ready", {31'b0, ready_o}, 32'd0);
        checkOutput("reset stallreq", {31'b0, stallreq_o}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        runDivide("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
        runDivide("remu 100/7", REMU, 32'd100, 32'd7, 32'd2, 33, 0);
        runDivide("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        runDivide("rem -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        runDivide("div -7/-2", DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 33, 0);
        runDivide("rem 7/-2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);

        runDivide("divu 5/0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        runDivide("remu 5/0", REMU, 32'd5, 32'd0, 32'd5, 1, 0);
        runDivide("div 5/0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
        runDivide("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
        runDivide("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);

        // Branch flush in cycle 10 of CALC; new divide two cycles later.
        readyBad = 1'b0;
        applyStimulus(1'b1, DIVU, 32'd1000, 32'd3, 1'b0, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (ready_o) readyBad = 1'b1;
        end
        flush_i = 1'b1;
        #1;
        checkOutput("flush stallreq", {31'b0, stallreq_o}, 32'd0);
        tick();
        applyStimulus(1'b0, DIVU, 32'd1000, 32'd3, 1'b0, 1'b0);
        #1;
        if (ready_o) readyBad = 1'b1;
        checkOutput("flush ready never", {31'b0, readyBad}, 32'd0);
        tick();
        runDivide("divu 9/3 after flush", DIVU, 32'd9, 32'd3, 32'd3, 33, 0);

        // Flush while DONE is held by a stall must still discard the result.
        applyStimulus(1'b1, DIVU, 32'd5, 32'd0, 1'b0, 1'b0);
        tick();
        checkOutput("flushdone ready", {31'b0, ready_o}, 32'd1);
        stall_i = 1'b1;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        checkOutput("flushdone dropped", {31'b0, ready_o}, 32'd0);
        applyStimulus(1'b0, DIVU, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();

        // Flush in IDLE together with start must not launch a divide.
        applyStimulus(1'b1, DIVU, 32'd5, 32'd0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, DIVU, 32'd5, 32'd0, 1'b0, 1'b0);
        #1;
        checkOutput("flushidle no start", {31'b0, ready_o}, 32'd0);
        tick();

        // start_i dropping mid-CALC aborts back to IDLE.
        applyStimulus(1'b1, DIVU, 32'd20, 32'd4, 1'b0, 1'b0);
        for (int c = 1; c <= 5; c++) tick();
        start_i = 1'b0;
        tick();
        checkOutput("abort ready", {31'b0, ready_o}, 32'd0);
        runDivide("divu 20/4 after abort", DIVU, 32'd20, 32'd4, 32'd5, 33, 0);

        runDivide("divu 50/5 stall", DIVU, 32'd50, 32'd5, 32'd10, 33, 4);

        // Reset during CALC.
        applyStimulus(1'b1, DIVU, 32'd1000, 32'd7, 1'b0, 1'b0);
        for (int c = 1; c <= 20; c++) tick();
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        checkOutput("rstcalc result", result_o, 32'd0);
        checkOutput("rstcalc ready", {31'b0, ready_o}, 32'd0);
        checkOutput("rstcalc stallreq", {31'b0, stallreq_o}, 32'd0);
        tick();
        rst = 1'b1;
        runDivide("divu ffffffff/1", DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 0);

        // Reset during a stalled DONE must clear the held result.
        applyStimulus(1'b1, DIVU, 32'd7, 32'd0, 1'b0, 1'b1);
        tick();
        checkOutput("rstdone ready before", {31'b0, ready_o}, 32'd1);
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        checkOutput("rstdone result", result_o, 32'd0);
        checkOutput("rstdone ready", {31'b0, ready_o}, 32'd0);
        tick();
        rst     = 1'b1;
        stall_i = 1'b0;
        tick();
        checkOutput("rstdone idle", {31'b0, ready_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
